shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arb_pkg.sv | 14 +
 rtl/shared_reg_arbiter_if.sv | 31 +++
 rtl/shared_reg_arbiter_rr_pick.sv | 33 +++
 rtl/shared_reg_arbiter.sv | 115 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding and index-width helper.
package shared_reg_arb_pkg;

  typedef enum logic {
    StIdle,
    StHold
  } state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, data, grant and register view.
interface shared_reg_arbiter_if
  import shared_reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) ();

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         dout;
  logic                      dout_valid;
  logic [IDX_W-1:0]          owner;
  logic                      busy;

  // Requesters drive req/wdata and observe the register.
  modport master (
    output req, wdata,
    input  gnt, dout, dout_valid, owner, busy
  );

  // The arbiter consumes req/wdata and drives the register view.
  modport slave (
    input  req, wdata,
    output gnt, dout, dout_valid, owner, busy
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning cyclically upward from ptr.
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  logic [IDX_W-1:0] sel;

  // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    sel    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sel = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!any && req[sel]) begin
        any         = 1'b1;
        winner      = sel;
        onehot[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shares one DATA_W register among NUM_REQ requesters: round-robin write arbitration,
// a one-cycle grant pulse to the winner, then a HOLD_CYCLES guard before re-arbitrating.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clr,
  shared_reg_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = idx_w(HOLD_CYCLES);

  if (NUM_REQ < 2 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("shared_reg_arbiter: NUM_REQ must be >= 2 and HOLD_CYCLES >= 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [DATA_W-1:0]  wdata_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_idx),
    .onehot (pick_onehot)
  );

  // One-hot mux of the winning requester's data.
  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_onehot[i]) wdata_sel = bus.wdata[i*DATA_W +: DATA_W];
    end
  end

  // Next-state: arbitrate in idle, count down the guard in hold; clr overrides data only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    owner_d = owner_q;
    gnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        // clr blocks arbitration that cycle: no grant, pointer stays.
        if (!clr && pick_any) begin
          dout_d  = wdata_sel;
          valid_d = 1'b1;
          owner_d = pick_idx;
          gnt_d   = pick_onehot;
          ptr_d   = IDX_W'((32'(pick_idx) + 32'd1) % NUM_REQ);
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
    if (clr) begin
      dout_d  = '0;
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state_q == StHold);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (NUM_REQ=4, DATA_W=8, HOLD_CYCLES=2).
module tb_shared_reg_arbiter;

  logic clk;
  logic rst;
  logic clr;
  int   n_cmp;
  int   n_err;

  shared_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  shared_reg_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .HOLD_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] dat [4];
    logic [3:0] oh;
    int         w;
    dat[0] = 8'hB0;
    dat[1] = 8'hA5;
    dat[2] = 8'hC2;
    dat[3] = 8'hD3;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    clr    = 1'b0;
    bus.req   = 4'b0000;
    bus.wdata = {dat[3], dat[2], dat[1], dat[0]};

    // 1. Reset then idle
    tick();
    tick();
    rst = 1'b0;
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_ptr", 32'(dut.ptr_q), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      chk("idle_busy", 32'(bus.busy), 32'h0);
      chk("idle_dout", 32'(bus.dout), 32'h0);
    end

    // 2. Single write from requester 1
    bus.req = 4'b0010;
    tick();
    chk("w1_dout", 32'(bus.dout), 32'hA5);
    chk("w1_valid", 32'(bus.dout_valid), 32'h1);
    chk("w1_owner", 32'(bus.owner), 32'h1);
    chk("w1_gnt", 32'(bus.gnt), 32'b0010);
    chk("w1_busy", 32'(bus.busy), 32'h1);
    chk("w1_ptr", 32'(dut.ptr_q), 32'h2);
    bus.req = 4'b0000;
    tick();
    chk("w1_gnt_off", 32'(bus.gnt), 32'h0);
    chk("w1_busy2", 32'(bus.busy), 32'h1);
    tick();
    chk("w1_busy_end", 32'(bus.busy), 32'h0);
    chk("w1_dout_hold", 32'(bus.dout), 32'hA5);

    // 3. Round-robin fairness with all requesters active, starting at ptr=2
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w  = (2 + g) % 4;
      oh = 4'b0001 << w;
      tick();
      chk("rr_gnt", 32'(bus.gnt), 32'(oh));
      chk("rr_dout", 32'(bus.dout), 32'(dat[w]));
      chk("rr_owner", 32'(bus.owner), 32'(w));
      if (g == 4) bus.req = 4'b0000;
      tick();
      chk("rr_gap1", 32'(bus.gnt), 32'h0);
      chk("rr_busy", 32'(bus.busy), 32'h1);
      tick();
      chk("rr_gap2", 32'(bus.gnt), 32'h0);
      chk("rr_idle", 32'(bus.busy), 32'h0);
    end

    // 4. Wrap-around: ptr=3, req=1001 grants 3 then 0
    chk("wrap_ptr", 32'(dut.ptr_q), 32'h3);
    bus.req = 4'b1001;
    tick();
    chk("wrap_gnt3", 32'(bus.gnt), 32'b1000);
    chk("wrap_dout3", 32'(bus.dout), 32'hD3);
    tick();
    tick();
    tick();
    chk("wrap_gnt0", 32'(bus.gnt), 32'b0001);
    chk("wrap_dout0", 32'(bus.dout), 32'hB0);
    chk("wrap_ptr1", 32'(dut.ptr_q), 32'h1);
    bus.req = 4'b0000;
    tick();
    tick();

    // 5. clr collides with a pending request in idle
    clr     = 1'b1;
    bus.req = 4'b0100;
    tick();
    chk("clr_dout", 32'(bus.dout), 32'h0);
    chk("clr_valid", 32'(bus.dout_valid), 32'h0);
    chk("clr_gnt", 32'(bus.gnt), 32'h0);
    chk("clr_busy", 32'(bus.busy), 32'h0);
    chk("clr_owner", 32'(bus.owner), 32'h0);
    chk("clr_ptr", 32'(dut.ptr_q), 32'h1);
    clr = 1'b0;
    tick();
    chk("clr_next_gnt", 32'(bus.gnt), 32'b0100);
    chk("clr_next_dout", 32'(bus.dout), 32'hC2);
    chk("clr_next_valid", 32'(bus.dout_valid), 32'h1);
    chk("clr_next_owner", 32'(bus.owner), 32'h2);
    bus.req = 4'b0000;
    tick();
    tick();

    // 6. Reset during the grant cycle
    bus.req = 4'b1000;
    tick();
    chk("rh_gnt", 32'(bus.gnt), 32'b1000);
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    chk("rh_gnt_off", 32'(bus.gnt), 32'h0);
    chk("rh_dout", 32'(bus.dout), 32'h0);
    chk("rh_valid", 32'(bus.dout_valid), 32'h0);
    chk("rh_busy", 32'(bus.busy), 32'h0);
    chk("rh_owner", 32'(bus.owner), 32'h0);
    chk("rh_ptr", 32'(dut.ptr_q), 32'h0);
    rst     = 1'b0;
    bus.req = 4'b1000;
    tick();
    chk("rh_regnt", 32'(bus.gnt), 32'b1000);
    chk("rh_redout", 32'(bus.dout), 32'hD3);
    chk("rh_reowner", 32'(bus.owner), 32'h3);
    chk("rh_reptr", 32'(dut.ptr_q), 32'h0);
    bus.req = 4'b0000;
    tick();
    chk("rh_pulse", 32'(bus.gnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
